calc_exec: RTL and testbench
============================

# calc_exec

Multi-cycle arithmetic sequencer for the calculator. It accepts two decimal operands (0–99) and an operator code from the keypad front-end FSM, and executes add, subtract, shift-add multiply or restoring divide on a single shared adder. It converts the result to BCD digits for the segment display driver and reports completion with a `done` pulse. It sits between the key-entry state machine and the digit registers feeding the 74HC595 display driver.

## Interface
- `OPW`, 7, operand width in bits (holds 0–99)
- `RESW`, 14, result width in bits (holds up to 9801)
- `clk`  in  1  system clock
- `rst_n`  in  1  reset; one clock, asynchronous, active-low
- `start`  in  1  one-cycle request pulse; sampled only in IDLE
- `clr`  in  1  synchronous abort/clear (keypad C)
- `op`  in  4  4'ha add, 4'hb sub, 4'hc mul, 4'hd div
- `a`  in  OPW  operand 1, binary
- `b`  in  OPW  operand 2, binary
- `busy`  out  1  high whenever state != IDLE
- `done`  out  1  one-cycle pulse when results update
- `err`  out  1  divide-by-zero, bad op, or operand > 99
- `neg`  out  1  result negative (sub only)
- `d3,d2,d1,d0`  out  4 each  BCD result digits, thousands..ones
- `rem_o`  out  OPW  division remainder; 0 for other ops

## Operation
- States: IDLE, LOAD, EXEC, CONV, DONE.
- **IDLE:** `start=1` latches `a`, `b` and `op`, then goes to LOAD. `start` outside IDLE is ignored (no queuing).
- **LOAD:** checks the request.
  - Error condition (`op` outside a..d, `a>99`, `b>99`, or `op=d` with `b=0`): go to DONE with `err=1`, all digits 0, `neg=0`, `rem_o=0`.
  - Otherwise clear the accumulator and the iteration counter, then go to EXEC.
- **EXEC:**
  - Add: acc = a+b in 1 cycle.
  - Sub: acc = |a−b| in 1 cycle; `neg`=(a<b); a result of 0 is never negative.
  - Mul: 7 iterations, LSB-first shift-add: acc += (b[i] ? a<<i : 0).
  - Div: 7 iterations, restoring, MSB-first; quotient goes to acc, remainder to `rem_o`.
  - Counter counts 0..6 and the state exits after the last iteration.
- **CONV:** 14-iteration double-dabble of acc (RESW bits) into 4 BCD digits, then DONE.
- **DONE:** registers digits, `neg`, `err` and `rem_o` to the outputs, pulses `done`, returns to IDLE.
- Outputs hold their values until the next DONE, or until `clr` or reset.
- `clr` has priority over everything, including `start` in the same cycle. Next cycle: IDLE, all outputs at reset values, `done` not pulsed.
- All arithmetic is unsigned. Intermediate widths are RESW+1; no overflow is possible within the 0–99 operand range.

## Timing
- All outputs are registered.
- Reset values: `busy=0`, `done=0`, `err=0`, `neg=0`, `d3..d0=0`, `rem_o=0`; state IDLE.
- Latency, counted as the cycle index of `done` with the `start` sampling edge as cycle 0:
  - Add/sub: 1 (LOAD) + 1 (EXEC) + 14 (CONV) + 1 = `done` in cycle 17.
  - Mul/div: 1 + 7 + 14 + 1 = `done` in cycle 23.
  - Error: 1 + 1 = `done` in cycle 2.
- `busy` rises in cycle 1 and falls in the cycle after `done`. A new `start` can be accepted in that same cycle.
- Asserting `rst_n` mid-operation clears immediately and asynchronously; no partial result is written.

## Structure
- Package `calc_pkg` holds:
  - opcode constants `OP_ADD`=4'ha, `OP_SUB`=4'hb, `OP_MUL`=4'hc, `OP_DIV`=4'hd, `KEY_EQ`=4'he, `KEY_CLR`=4'hf
  - the state enum
  - `OPW`/`RESW` defaults and `MAX_OPERAND`=99
- One sub-module, `bin2bcd_seq`: sequential double-dabble with `start`, `busy`/`done`, a RESW-bit binary input and 4 BCD digit outputs.
  - Driven from CONV; its `done` advances to DONE.
  - The 14-cycle CONV time is its contract.
- The shared adder/subtractor in EXEC is a single instance, muxed per op and iteration.

## Test plan
- a=12, b=34, op=a → `done` in cycle 17; digits 0,0,4,6; `neg=0`; `err=0`.
- a=5, b=27, op=b → digits 0,0,2,2; `neg=1`. Then a=27, b=27 → 0,0,0,0 with `neg=0`.
- a=99, b=99, op=c → `done` in cycle 23; digits 9,8,0,1.
- a=99, b=7, op=d → digits 0,0,1,4; `rem_o=1`. Then a=5, b=0, op=d → `done` in cycle 2; `err=1`; digits 0.
- `start` pulsed at cycle 5 during an active mul → ignored, and the original result is unchanged. `start` in the cycle after `done` → accepted.
- `clr` at cycle 10 of a mul → IDLE next cycle; all outputs 0; no `done`. Same for `rst_n` low mid-CONV. `clr` and `start` together in IDLE → stays IDLE.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared constants, state type and the double-dabble step for the calculator datapath.
package calc_pkg;

    localparam int unsigned OPW_DEFAULT  = 7;
    localparam int unsigned RESW_DEFAULT = 14;
    localparam int unsigned MAX_OPERAND  = 99;

    localparam logic [3:0] OP_ADD  = 4'ha;
    localparam logic [3:0] OP_SUB  = 4'hb;
    localparam logic [3:0] OP_MUL  = 4'hc;
    localparam logic [3:0] OP_DIV  = 4'hd;
    localparam logic [3:0] KEY_EQ  = 4'he;
    localparam logic [3:0] KEY_CLR = 4'hf;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StExec,
        StConv,
        StDone
    } calc_state_e;

    // One double-dabble iteration: add 3 to every digit >= 5, then shift in the next binary bit.
    function automatic logic [15:0] dabble_step(input logic [15:0] bcd, input logic bin_msb);
        logic [15:0] adj;
        for (int i = 0; i < 4; i++) begin
            adj[4*i +: 4] = (bcd[4*i +: 4] >= 4'd5) ? bcd[4*i +: 4] + 4'd3 : bcd[4*i +: 4];
        end
        return (adj << 1) | {15'b0, bin_msb};
    endfunction

endpackage

// File: rtl/calc_exec_if.sv
// Request/result bundle between the key-entry FSM (master) and the sequencer (slave).
interface calc_exec_if
    import calc_pkg::*;
#(
    parameter int unsigned OPW = OPW_DEFAULT
) ();

    logic           start;
    logic           clr;
    logic [3:0]     op;
    logic [OPW-1:0] a;
    logic [OPW-1:0] b;
    logic           busy;
    logic           done;
    logic           err;
    logic           neg;
    logic [3:0]     d3;
    logic [3:0]     d2;
    logic [3:0]     d1;
    logic [3:0]     d0;
    logic [OPW-1:0] rem_o;

    modport master (
        output start, clr, op, a, b,
        input  busy, done, err, neg, d3, d2, d1, d0, rem_o
    );

    modport slave (
        input  start, clr, op, a, b,
        output busy, done, err, neg, d3, d2, d1, d0, rem_o
    );

endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble: RESW iterations from the start edge, digits held after done.
module bin2bcd_seq
    import calc_pkg::*;
#(
    parameter int unsigned RESW = RESW_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_clr,
    input  logic            i_start,
    input  logic [RESW-1:0] i_bin,
    output logic            o_busy,
    output logic            o_done,
    output logic [3:0]      o_d3,
    output logic [3:0]      o_d2,
    output logic [3:0]      o_d1,
    output logic [3:0]      o_d0
);

    localparam int unsigned CW = $clog2(RESW);

    logic [RESW-1:0] r_bin;
    logic [15:0]     r_bcd;
    logic [CW-1:0]   r_cnt;
    logic            r_busy;
    logic            r_done;

    // The start edge already performs the first iteration on i_bin, so the whole
    // conversion takes exactly RESW edges and done is visible one cycle later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bin  <= '0;
            r_bcd  <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else if (i_clr) begin
            r_bin  <= '0;
            r_bcd  <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (!r_busy && i_start) begin
                r_bcd  <= dabble_step(16'h0, i_bin[RESW-1]);
                r_bin  <= i_bin << 1;
                r_cnt  <= CW'(1);
                r_busy <= 1'b1;
            end else if (r_busy) begin
                r_bcd <= dabble_step(r_bcd, r_bin[RESW-1]);
                r_bin <= r_bin << 1;
                r_cnt <= r_cnt + 1'b1;
                if (r_cnt == CW'(RESW - 1)) begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                end
            end
        end
    end

    assign o_busy = r_busy;
    assign o_done = r_done;
    assign o_d3   = r_bcd[15:12];
    assign o_d2   = r_bcd[11:8];
    assign o_d1   = r_bcd[7:4];
    assign o_d0   = r_bcd[3:0];

endmodule

// File: rtl/calc_exec.sv
// Multi-cycle add/sub/mul/div sequencer on one shared adder, with BCD result conversion.
module calc_exec
    import calc_pkg::*;
#(
    parameter int unsigned OPW  = OPW_DEFAULT,
    parameter int unsigned RESW = RESW_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    calc_exec_if.slave bus
);

    localparam int unsigned AW = RESW + 1;
    localparam int unsigned CW = $clog2(OPW);

    calc_state_e    r_state;
    logic [OPW-1:0] r_a;
    logic [OPW-1:0] r_b;
    logic [3:0]     r_op;
    logic [RESW-1:0] r_acc;
    logic [OPW-1:0] r_rem;
    logic [CW-1:0]  r_cnt;

    logic           r_busy;
    logic           r_done;
    logic           r_err;
    logic           r_neg;
    logic [3:0]     r_d3;
    logic [3:0]     r_d2;
    logic [3:0]     r_d1;
    logic [3:0]     r_d0;
    logic [OPW-1:0] r_rem_o;

    logic            w_a_lt_b;
    logic            w_req_err;
    logic            w_exec_last;
    logic [CW-1:0]   w_div_idx;
    logic [AW-1:0]   w_add_x;
    logic [AW-1:0]   w_add_y;
    logic            w_add_sub;
    logic [AW-1:0]   w_sum;
    logic [RESW-1:0] w_acc_next;
    logic [OPW-1:0]  w_rem_next;
    logic            w_bcd_start;
    logic            w_bcd_busy;
    logic            w_bcd_done;
    logic [3:0]      w_bcd_d3;
    logic [3:0]      w_bcd_d2;
    logic [3:0]      w_bcd_d1;
    logic [3:0]      w_bcd_d0;

    assign w_a_lt_b  = r_a < r_b;
    assign w_req_err = (r_op < OP_ADD) || (r_op > OP_DIV) ||
                       (r_a > OPW'(MAX_OPERAND)) || (r_b > OPW'(MAX_OPERAND)) ||
                       ((r_op == OP_DIV) && (r_b == '0));
    assign w_exec_last = (r_op == OP_ADD) || (r_op == OP_SUB) || (r_cnt == CW'(OPW - 1));
    assign w_div_idx   = CW'(OPW - 1) - r_cnt;

    // Operand mux for the single adder; sub swaps operands so the result is |a-b|.
    always_comb begin
        w_add_x   = '0;
        w_add_y   = '0;
        w_add_sub = 1'b0;
        case (r_op)
            OP_ADD: begin
                w_add_x = AW'(r_a);
                w_add_y = AW'(r_b);
            end
            OP_SUB: begin
                w_add_x   = AW'(w_a_lt_b ? r_b : r_a);
                w_add_y   = AW'(w_a_lt_b ? r_a : r_b);
                w_add_sub = 1'b1;
            end
            OP_MUL: begin
                w_add_x = AW'(r_acc);
                w_add_y = r_b[r_cnt] ? (AW'(r_a) << r_cnt) : '0;
            end
            OP_DIV: begin
                // Partial remainder shifted left with the next dividend bit, trial-subtract b.
                w_add_x   = AW'({r_rem, r_a[w_div_idx]});
                w_add_y   = AW'(r_b);
                w_add_sub = 1'b1;
            end
            default: ;
        endcase
    end

    assign w_sum = w_add_x + (w_add_sub ? ~w_add_y : w_add_y) + AW'(w_add_sub);

    // Accumulator/remainder update; for divide the top sum bit is the borrow (restore).
    always_comb begin
        w_acc_next = w_sum[RESW-1:0];
        w_rem_next = r_rem;
        if (r_op == OP_DIV) begin
            w_acc_next = {r_acc[RESW-2:0], ~w_sum[RESW]};
            w_rem_next = w_sum[RESW] ? w_add_x[OPW-1:0] : w_sum[OPW-1:0];
        end
    end

    // Converter is launched on the final EXEC edge with the final acc value so CONV is 14 cycles.
    assign w_bcd_start = (r_state == StExec) && w_exec_last && !w_bcd_busy;

    bin2bcd_seq #(
        .RESW (RESW)
    ) u_bin2bcd (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_clr   (bus.clr),
        .i_start (w_bcd_start),
        .i_bin   (w_acc_next),
        .o_busy  (w_bcd_busy),
        .o_done  (w_bcd_done),
        .o_d3    (w_bcd_d3),
        .o_d2    (w_bcd_d2),
        .o_d1    (w_bcd_d1),
        .o_d0    (w_bcd_d0)
    );

    // Main sequencer; result outputs are written on the edge entering DONE so done marks them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
            r_a     <= '0;
            r_b     <= '0;
            r_op    <= '0;
            r_acc   <= '0;
            r_rem   <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_neg   <= 1'b0;
            r_d3    <= '0;
            r_d2    <= '0;
            r_d1    <= '0;
            r_d0    <= '0;
            r_rem_o <= '0;
        end else if (bus.clr) begin
            r_state <= StIdle;
            r_a     <= '0;
            r_b     <= '0;
            r_op    <= '0;
            r_acc   <= '0;
            r_rem   <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_neg   <= 1'b0;
            r_d3    <= '0;
            r_d2    <= '0;
            r_d1    <= '0;
            r_d0    <= '0;
            r_rem_o <= '0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (bus.start) begin
                        r_a     <= bus.a;
                        r_b     <= bus.b;
                        r_op    <= bus.op;
                        r_busy  <= 1'b1;
                        r_state <= StLoad;
                    end
                end
                StLoad: begin
                    if (w_req_err) begin
                        r_err   <= 1'b1;
                        r_neg   <= 1'b0;
                        r_d3    <= '0;
                        r_d2    <= '0;
                        r_d1    <= '0;
                        r_d0    <= '0;
                        r_rem_o <= '0;
                        r_done  <= 1'b1;
                        r_state <= StDone;
                    end else begin
                        r_acc   <= '0;
                        r_rem   <= '0;
                        r_cnt   <= '0;
                        r_state <= StExec;
                    end
                end
                StExec: begin
                    r_acc <= w_acc_next;
                    r_rem <= w_rem_next;
                    r_cnt <= r_cnt + 1'b1;
                    if (w_exec_last) begin
                        r_state <= StConv;
                    end
                end
                StConv: begin
                    if (w_bcd_done) begin
                        r_err   <= 1'b0;
                        r_neg   <= (r_op == OP_SUB) && w_a_lt_b;
                        r_d3    <= w_bcd_d3;
                        r_d2    <= w_bcd_d2;
                        r_d1    <= w_bcd_d1;
                        r_d0    <= w_bcd_d0;
                        r_rem_o <= (r_op == OP_DIV) ? r_rem : '0;
                        r_done  <= 1'b1;
                        r_state <= StDone;
                    end
                end
                StDone: begin
                    r_busy  <= 1'b0;
                    r_state <= StIdle;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign bus.busy  = r_busy;
    assign bus.done  = r_done;
    assign bus.err   = r_err;
    assign bus.neg   = r_neg;
    assign bus.d3    = r_d3;
    assign bus.d2    = r_d2;
    assign bus.d1    = r_d1;
    assign bus.d0    = r_d0;
    assign bus.rem_o = r_rem_o;

endmodule

// File: tb/tb_calc_exec.sv
// Directed table-driven bench for calc_exec plus hand-written abort/overlap sequences.
module tb_calc_exec;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    calc_exec_if #(.OPW(7)) bus ();

    calc_exec #(
        .OPW  (7),
        .RESW (14)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [6:0]  a;
        logic [6:0]  b;
        logic [3:0]  op;
        int          lat;
        logic [15:0] digits;
        logic        neg;
        logic        err;
        logic [6:0]  rem;
    } vec_t;

    vec_t vecs[17];
    int   n_pass  = 0;
    int   n_total = 0;

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    function automatic int digits();
        return int'({bus.d3, bus.d2, bus.d1, bus.d0});
    endfunction

    // Starts an operation and returns the cycle index of done (bounded); optionally pulses a
    // stray start with different operands at cycle inject_at.
    task automatic run_op(input logic [6:0] a, input logic [6:0] b, input logic [3:0] op,
                          input int inject_at, output int lat);
        bus.a     = a;
        bus.b     = b;
        bus.op    = op;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        lat = 1;
        check("busy_rise", bus.busy, 1);
        while (!bus.done && lat < 60) begin
            if (lat == inject_at) begin
                bus.start = 1'b1;
                bus.a     = 7'd1;
                bus.b     = 7'd1;
                bus.op    = 4'ha;
            end else begin
                bus.start = 1'b0;
            end
            @(posedge clk); #1;
            lat++;
        end
        bus.start = 1'b0;
    endtask

    task automatic quiet(input string name, input int n);
        int seen = 0;
        repeat (n) begin
            @(posedge clk); #1;
            if (bus.done || bus.busy) seen++;
        end
        check(name, seen, 0);
    endtask

    initial begin
        int lat;

        vecs[0]  = '{7'd12,  7'd34,  4'ha, 17, 16'h0046, 1'b0, 1'b0, 7'd0};
        vecs[1]  = '{7'd5,   7'd27,  4'hb, 17, 16'h0022, 1'b1, 1'b0, 7'd0};
        vecs[2]  = '{7'd27,  7'd27,  4'hb, 17, 16'h0000, 1'b0, 1'b0, 7'd0};
        vecs[3]  = '{7'd99,  7'd99,  4'hc, 23, 16'h9801, 1'b0, 1'b0, 7'd0};
        vecs[4]  = '{7'd99,  7'd7,   4'hd, 23, 16'h0014, 1'b0, 1'b0, 7'd1};
        vecs[5]  = '{7'd5,   7'd0,   4'hd, 2,  16'h0000, 1'b0, 1'b1, 7'd0};
        vecs[6]  = '{7'd0,   7'd0,   4'ha, 17, 16'h0000, 1'b0, 1'b0, 7'd0};
        vecs[7]  = '{7'd99,  7'd99,  4'ha, 17, 16'h0198, 1'b0, 1'b0, 7'd0};
        vecs[8]  = '{7'd50,  7'd20,  4'hb, 17, 16'h0030, 1'b0, 1'b0, 7'd0};
        vecs[9]  = '{7'd0,   7'd77,  4'hc, 23, 16'h0000, 1'b0, 1'b0, 7'd0};
        vecs[10] = '{7'd64,  7'd2,   4'hc, 23, 16'h0128, 1'b0, 1'b0, 7'd0};
        vecs[11] = '{7'd98,  7'd99,  4'hd, 23, 16'h0000, 1'b0, 1'b0, 7'd98};
        vecs[12] = '{7'd97,  7'd10,  4'hd, 23, 16'h0009, 1'b0, 1'b0, 7'd7};
        vecs[13] = '{7'd1,   7'd2,   4'h3, 2,  16'h0000, 1'b0, 1'b1, 7'd0};
        vecs[14] = '{7'd100, 7'd1,   4'ha, 2,  16'h0000, 1'b0, 1'b1, 7'd0};
        vecs[15] = '{7'd4,   7'd4,   4'he, 2,  16'h0000, 1'b0, 1'b1, 7'd0};
        vecs[16] = '{7'd3,   7'd100, 4'hb, 2,  16'h0000, 1'b0, 1'b1, 7'd0};

        bus.start = 1'b0;
        bus.clr   = 1'b0;
        bus.op    = 4'h0;
        bus.a     = 7'd0;
        bus.b     = 7'd0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_err", bus.err, 0);
        check("rst_neg", bus.neg, 0);
        check("rst_digits", digits(), 0);
        check("rst_rem", bus.rem_o, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Table: each new start lands in the cycle right after the previous busy drop
        for (int i = 0; i < 17; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].op, 0, lat);
            check($sformatf("v%0d_lat", i), lat, vecs[i].lat);
            check($sformatf("v%0d_digits", i), digits(), int'(vecs[i].digits));
            check($sformatf("v%0d_neg", i), bus.neg, vecs[i].neg);
            check($sformatf("v%0d_err", i), bus.err, vecs[i].err);
            check($sformatf("v%0d_rem", i), bus.rem_o, vecs[i].rem);
            @(posedge clk); #1;
            check($sformatf("v%0d_done_pulse", i), bus.done, 0);
            check($sformatf("v%0d_busy_fall", i), bus.busy, 0);
        end

        // clr at cycle 10 of a multiply (err is still set from the last table entry)
        bus.a     = 7'd99;
        bus.b     = 7'd99;
        bus.op    = 4'hc;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        bus.clr = 1'b1;
        @(posedge clk); #1;
        bus.clr = 1'b0;
        check("clr_busy", bus.busy, 0);
        check("clr_done", bus.done, 0);
        check("clr_err", bus.err, 0);
        check("clr_digits", digits(), 0);
        quiet("clr_quiet", 40);

        // Stray start during a multiply is ignored; start right after done is accepted
        run_op(7'd99, 7'd99, 4'hc, 5, lat);
        check("ign_lat", lat, 23);
        check("ign_digits", digits(), 16'h9801);
        @(posedge clk); #1;
        run_op(7'd12, 7'd34, 4'ha, 0, lat);
        check("next_lat", lat, 17);
        check("next_digits", digits(), 16'h0046);
        @(posedge clk); #1;

        // Asynchronous reset in the middle of CONV
        bus.a     = 7'd99;
        bus.b     = 7'd99;
        bus.op    = 4'hc;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (11) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_busy", bus.busy, 0);
        check("arst_digits", digits(), 0);
        check("arst_done", bus.done, 0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        quiet("arst_quiet", 40);
        check("arst_digits_after", digits(), 0);

        // clr and start together in IDLE
        bus.a     = 7'd12;
        bus.b     = 7'd34;
        bus.op    = 4'ha;
        bus.start = 1'b1;
        bus.clr   = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.clr   = 1'b0;
        check("clrstart_busy", bus.busy, 0);
        quiet("clrstart_quiet", 25);
        check("clrstart_digits", digits(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
